// File: rtl/array_11_pkg.sv
// Shared widths and request record for the array_11 SRAM front end.
package array_11_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 228;
    localparam int MASK_W = 2;
    localparam int LANE_W = DATA_W / MASK_W;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [MASK_W-1:0] mask;
        logic [DATA_W-1:0] data;
    } req_t;
endpackage

// File: rtl/array_11_resp_queue.sv
// Small circular FIFO holding read responses the consumer has not yet taken.
module array_11_resp_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 228
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/array_11_req_ctrl.sv
// Valid/ready request front end for the array_11_ext RW0 port with in-order,
// backpressured read responses.
module array_11_req_ctrl
    import array_11_pkg::*;
#(
    parameter int RESP_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [MASK_W-1:0] req_mask,
    input  logic [DATA_W-1:0] req_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    req_t              req;
    logic [CNT_W-1:0]  cnt;
    logic              inflight;
    logic              fire;
    logic              read_fire;
    logic              resp_fire;
    logic              q_push;
    logic              q_pop;
    logic              q_empty;
    logic              q_full;
    logic [DATA_W-1:0] q_head;

    assign req = '{write: req_write, addr: req_addr, mask: req_mask, data: req_data};

    // cnt covers queued entries plus the read in flight, so the queue can never overflow
    assign req_ready = !reset && (cnt < CNT_W'(RESP_DEPTH));
    assign fire      = req_valid && req_ready;
    assign read_fire = fire && !req.write;

    assign sram_en    = fire;
    assign sram_wmode = req.write;
    assign sram_addr  = req.addr;
    assign sram_wmask = req.mask;
    assign sram_wdata = req.data;

    // rdata is only valid for one cycle, so it either flows straight out or is parked
    assign resp_valid = !reset && (inflight || !q_empty);
    assign resp_data  = q_empty ? sram_rdata : q_head;
    assign resp_fire  = resp_valid && resp_ready;
    assign q_push     = !reset && inflight && (!q_empty || !resp_ready);
    assign q_pop      = resp_fire && !q_empty;

    array_11_resp_queue #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (DATA_W)
    ) u_resp_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (q_push),
        .push_data (sram_rdata),
        .pop       (q_pop),
        .head      (q_head),
        .empty     (q_empty),
        .full      (q_full)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt      <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= read_fire;
            case ({read_fire, resp_fire})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(q_push && q_full)) else $error("response queue push while full");
        end
    end
endmodule
